spi_sdinit: RTL and testbench

- Power-up/initialisation sequencer for an SD card in SPI mode.
- Sits above the SPI command engine: first drives the shared byte-level SPI port directly to send the wake-up clocks.
- Then issues CMD0, CMD8, the CMD55/ACMD41 loop and CMD58 through the command engine's strobe/response interface.
- Reports card version, capacity class (CCS) and a 3-bit error code to the host.

---
 rtl/spi_sdinit.sv | 217 +++++++++++++++++++++
 tb/tb_spi_sdinit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sdinit.sv
// SD card SPI-mode initialisation sequencer.
// Sends DUMMY_BYTES wake-up bytes (0xFF, card deselected) on the shared byte
// port, then walks CMD0, CMD8, the CMD55/ACMD41 loop and CMD58 through the
// command engine. Reports card version, capacity class and an error code.
//
// Ports:
//   i_clk, i_reset_n            clock, async active-low reset
//   i_start / o_busy / o_done   host control (o_done is a one-cycle pulse)
//   o_err[2:0], o_v2, o_ccs     result, held until the next i_start
//   o_cs_active                 card-select request (low during dummy bytes)
//   o_ll_stb, o_ll_byte, i_ll_busy              byte-port handshake
//   o_cmd_stb/_type/_cmd/_data, i_cmd_busy      command engine request
//   i_cmd_rxvalid, i_cmd_response[39:0]         command engine response
//   o_cmd_reset                 engine reset pulse after a response timeout
//
// State table:
//   IDLE  | waiting for i_start
//   DUMMY | sending wake-up bytes with CS inactive
//   ISSUE | waiting for the engine to go idle, then strobing cmd_sel
//   WAIT  | waiting for the response to cmd_sel or a timeout
//   DONE  | one-cycle completion pulse
module spi_sdinit #(
  parameter int unsigned DUMMY_BYTES    = 10,
  parameter int unsigned ACMD41_RETRIES = 1000,
  parameter int unsigned RESP_TIMEOUT   = 65535
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_err,
  output logic        o_v2,
  output logic        o_ccs,
  output logic        o_cs_active,
  output logic        o_ll_stb,
  output logic [7:0]  o_ll_byte,
  input  logic        i_ll_busy,
  output logic        o_cmd_stb,
  output logic [1:0]  o_cmd_type,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_data,
  input  logic        i_cmd_busy,
  input  logic        i_cmd_rxvalid,
  input  logic [39:0] i_cmd_response,
  output logic        o_cmd_reset
);

  typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd_sel, cmd_nxt;
  logic [15:0] dummy_cnt;
  logic [15:0] retry_cnt;
  logic [19:0] tmo_cnt;
  logic [2:0]  err_nxt;
  logic        v2_nxt, ccs_nxt;
  logic        load_retry, dec_retry;
  logic [7:0]  r1;
  logic        unused_resp;

  assign r1          = i_cmd_response[39:32];
  assign o_ll_byte   = 8'hFF;
  assign unused_resp = ^{i_cmd_response[31], i_cmd_response[29:12]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      cmd_sel <= C_CMD0;
      o_err   <= 3'd0;
      o_v2    <= 1'b0;
      o_ccs   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cmd_sel <= cmd_nxt;
      o_err   <= err_nxt;
      o_v2    <= v2_nxt;
      o_ccs   <= ccs_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dummy_cnt <= 16'd0;
      retry_cnt <= 16'd0;
      tmo_cnt   <= 20'd0;
    end else begin
      if (state == S_IDLE && i_start)
        dummy_cnt <= 16'(DUMMY_BYTES);
      else if (o_ll_stb && !i_ll_busy)
        dummy_cnt <= dummy_cnt - 16'd1;

      if (load_retry)
        retry_cnt <= 16'(ACMD41_RETRIES);
      else if (dec_retry)
        retry_cnt <= retry_cnt - 16'd1;

      if (o_cmd_stb)
        tmo_cnt <= 20'd0;
      else if (state == S_WAIT)
        tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cmd_sel;
    err_nxt     = o_err;
    v2_nxt      = o_v2;
    ccs_nxt     = o_ccs;
    load_retry  = 1'b0;
    dec_retry   = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_cs_active = 1'b1;
    o_ll_stb    = 1'b0;
    o_cmd_stb   = 1'b0;
    o_cmd_type  = 2'b00;
    o_cmd       = 6'd0;
    o_cmd_data  = 32'd0;
    o_cmd_reset = 1'b0;

    case (state)
      S_IDLE: begin
        o_busy      = 1'b0;
        o_cs_active = 1'b0;
        if (i_start) begin
          err_nxt   = 3'd0;
          v2_nxt    = 1'b0;
          ccs_nxt   = 1'b0;
          state_nxt = S_DUMMY;
        end
      end
      S_DUMMY: begin
        o_cs_active = 1'b0;
        if (dummy_cnt == 16'd0) begin
          cmd_nxt    = C_CMD0;
          load_retry = 1'b1;
          state_nxt  = S_ISSUE;
        end else begin
          o_ll_stb = 1'b1;
        end
      end
      S_ISSUE: begin
        case (cmd_sel)
          C_CMD8:   begin o_cmd = 6'd8;  o_cmd_type = 2'b10; o_cmd_data = 32'h0000_01AA; end
          C_CMD55:  begin o_cmd = 6'd55; end
          C_ACMD41: begin o_cmd = 6'd41; o_cmd_data = o_v2 ? 32'h4000_0000 : 32'd0; end
          C_CMD58:  begin o_cmd = 6'd58; o_cmd_type = 2'b10; end
          default:  ;
        endcase
        if (!i_cmd_busy) begin
          o_cmd_stb = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the expiry cycle wins over the timeout.
        if (i_cmd_rxvalid) begin
          state_nxt = S_ISSUE;
          case (cmd_sel)
            C_CMD0:
              if (r1 == 8'h01) cmd_nxt = C_CMD8;
              else begin err_nxt = 3'd1; state_nxt = S_DONE; end
            C_CMD8:
              if (r1 == 8'h01 && i_cmd_response[11:0] == 12'h1AA) begin
                v2_nxt  = 1'b1;
                cmd_nxt = C_CMD55;
              end else if (r1 == 8'h05) begin
                v2_nxt  = 1'b0;
                cmd_nxt = C_CMD55;
              end else begin
                err_nxt   = 3'd2;
                state_nxt = S_DONE;
              end
            C_CMD55:
              if (r1 == 8'h00 || r1 == 8'h01) cmd_nxt = C_ACMD41;
              else begin err_nxt = 3'd4; state_nxt = S_DONE; end
            C_ACMD41:
              if (r1 == 8'h00) cmd_nxt = C_CMD58;
              else if (r1 == 8'h01) begin
                dec_retry = 1'b1;
                if (retry_cnt <= 16'd1) begin
                  err_nxt   = 3'd3;
                  state_nxt = S_DONE;
                end else begin
                  cmd_nxt = C_CMD55;
                end
              end else begin
                err_nxt   = 3'd4;
                state_nxt = S_DONE;
              end
            C_CMD58: begin
              state_nxt = S_DONE;
              if (r1 == 8'h00) ccs_nxt = o_v2 & i_cmd_response[30];
              else err_nxt = 3'd5;
            end
            default: state_nxt = S_DONE;
          endcase
        end else if (tmo_cnt == 20'(RESP_TIMEOUT - 1)) begin
          err_nxt     = 3'd6;
          o_cmd_reset = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_busy      = 1'b0;
        o_cs_active = 1'b0;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_sdinit.sv
module tb_spi_sdinit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy, o_done, o_v2, o_ccs, o_cs_active, o_ll_stb;
  logic [2:0]  o_err;
  logic [7:0]  o_ll_byte;
  logic        i_ll_busy = 1'b0;
  logic        o_cmd_stb, o_cmd_reset;
  logic [1:0]  o_cmd_type;
  logic [5:0]  o_cmd;
  logic [31:0] o_cmd_data;
  logic        i_cmd_busy = 1'b0;
  logic        i_cmd_rxvalid = 1'b0;
  logic [39:0] i_cmd_response = 40'd0;

  spi_sdinit #(.DUMMY_BYTES(10), .ACMD41_RETRIES(3), .RESP_TIMEOUT(100)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_v2(o_v2), .o_ccs(o_ccs),
    .o_cs_active(o_cs_active), .o_ll_stb(o_ll_stb), .o_ll_byte(o_ll_byte),
    .i_ll_busy(i_ll_busy), .o_cmd_stb(o_cmd_stb), .o_cmd_type(o_cmd_type),
    .o_cmd(o_cmd), .o_cmd_data(o_cmd_data), .i_cmd_busy(i_cmd_busy),
    .i_cmd_rxvalid(i_cmd_rxvalid), .i_cmd_response(i_cmd_response),
    .o_cmd_reset(o_cmd_reset)
  );

  always #5 clk = ~clk;

  typedef struct {logic [5:0] cmd; logic [1:0] typ; logic [31:0] data;} cmd_exp_t;
  typedef struct {bit ok; logic [39:0] r;} rsp_t;
  typedef struct {logic [2:0] err; logic v2; logic ccs;} done_exp_t;

  cmd_exp_t  exp_cmd_q[$];
  rsp_t      rsp_q[$];
  done_exp_t exp_done_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int byte_cnt = 0;
  int cyc = 0;
  int stb_cyc = 0;
  bit exp_tmo = 0;
  bit seen_acmd41 = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] cmd, input logic [1:0] typ, input logic [31:0] data,
                      input bit ok, input logic [39:0] r);
    cmd_exp_t c;
    rsp_t     s;
    c.cmd = cmd; c.typ = typ; c.data = data;
    s.ok = ok; s.r = r;
    exp_cmd_q.push_back(c);
    rsp_q.push_back(s);
  endtask

  task automatic push_done(input logic [2:0] err, input logic v2, input logic ccs);
    done_exp_t d;
    d.err = err; d.v2 = v2; d.ccs = ccs;
    exp_done_q.push_back(d);
  endtask

  // Card / command-engine model: busy from strobe until a cycle after the response.
  initial begin : card
    rsp_t rsp;
    forever begin
      @(negedge clk);
      if (rst_n && o_cmd_stb) begin
        if (rsp_q.size() == 0) begin
          rsp.ok = 0; rsp.r = '0;
        end else begin
          rsp = rsp_q.pop_front();
        end
        @(posedge clk); #1 i_cmd_busy = 1'b1;
        if (rsp.ok) begin
          repeat (2) @(posedge clk);
          #1;
          i_cmd_response = rsp.r;
          i_cmd_rxvalid  = 1'b1;
          @(posedge clk); #1 i_cmd_rxvalid = 1'b0;
          @(posedge clk); #1 i_cmd_busy = 1'b0;
        end else begin
          for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (o_cmd_reset || !rst_n) break;
          end
          i_cmd_busy = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cmd_exp_t  c;
    done_exp_t d;
    cyc++;
    if (!rst_n) begin
      byte_cnt = 0;
    end else begin
      if (o_ll_stb && o_cs_active) begin
        errors++;
        $display("FAIL ll_stb_with_cs: o_ll_stb=1 while o_cs_active=1");
      end
      if (o_ll_stb && !i_ll_busy) byte_cnt++;
      if (o_cmd_stb) begin
        stb_cyc = cyc;
        chk("stb_while_busy", 64'(i_cmd_busy), 64'd0);
        if (o_cmd == 6'd41) seen_acmd41 = 1;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd: got cmd %0d, expected none", o_cmd);
        end else begin
          c = exp_cmd_q.pop_front();
          chk("cmd_index", 64'(o_cmd), 64'(c.cmd));
          chk("cmd_type", 64'(o_cmd_type), 64'(c.typ));
          chk("cmd_data", 64'(o_cmd_data), 64'(c.data));
        end
        if (o_cmd == 6'd0) begin
          chk("dummy_bytes", 64'(byte_cnt), 64'd10);
          byte_cnt = 0;
        end
      end
      if (o_cmd_reset) begin
        chk("cmd_reset_expected", 64'(exp_tmo), 64'd1);
        chk("timeout_cycles", 64'(cyc - stb_cyc), 64'd100);
        exp_tmo = 0;
      end
      if (o_done) begin
        done_cnt++;
        chk("busy_at_done", 64'(o_busy), 64'd0);
        chk("cmds_left_at_done", 64'(exp_cmd_q.size()), 64'd0);
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got o_done=1, expected none");
        end else begin
          d = exp_done_q.pop_front();
          chk("done_err", 64'(o_err), 64'(d.err));
          chk("done_v2", 64'(o_v2), 64'(d.v2));
          chk("done_ccs", 64'(o_ccs), 64'(d.ccs));
        end
      end
    end
  end

  task automatic start_pulse();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input logic [2:0] exp_err);
    int start = done_cnt;
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (done_cnt != start) begin ok = 1; break; end
    end
    chk("done_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_held", 64'(o_err), 64'(exp_err));
    chk("idle_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, 64'({o_busy, o_done, o_err, o_v2, o_ccs, o_cs_active, o_ll_stb,
                             o_cmd_stb, o_cmd_type, o_cmd, o_cmd_data, o_cmd_reset}), 64'd0);
    chk({tag, "_ll_byte"}, 64'(o_ll_byte), 64'hFF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: SD v2 high-capacity card, one ACMD41 retry; stray i_start mid-run.
    push(6'd0, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd8, 2'b10, 32'h1AA, 1, 40'h01_000001AA);
    push(6'd55, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd41, 2'b00, 32'h40000000, 1, 40'h01_00000000);
    push(6'd55, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd41, 2'b00, 32'h40000000, 1, 40'h00_00000000);
    push(6'd58, 2'b10, 32'd0, 1, 40'h00_C0FF8000);
    push_done(3'd0, 1'b1, 1'b1);
    start_pulse();
    repeat (30) @(posedge clk);
    start_pulse();
    wait_done(3'd0);

    // 2: v1 card (CMD8 illegal), CMD58 without CCS.
    push(6'd0, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd8, 2'b10, 32'h1AA, 1, 40'h05_00000000);
    push(6'd55, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd41, 2'b00, 32'd0, 1, 40'h00_00000000);
    push(6'd58, 2'b10, 32'd0, 1, 40'h00_80FF8000);
    push_done(3'd0, 1'b0, 1'b0);
    start_pulse();
    wait_done(3'd0);

    // 3: CMD0 rejected.
    push(6'd0, 2'b00, 32'd0, 1, 40'hFF_00000000);
    push_done(3'd1, 1'b0, 1'b0);
    start_pulse();
    wait_done(3'd1);

    // 4: card never leaves idle: exactly three CMD55/ACMD41 pairs.
    push(6'd0, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd8, 2'b10, 32'h1AA, 1, 40'h01_000001AA);
    for (int i = 0; i < 3; i++) begin
      push(6'd55, 2'b00, 32'd0, 1, 40'h01_00000000);
      push(6'd41, 2'b00, 32'h40000000, 1, 40'h01_00000000);
    end
    push_done(3'd3, 1'b1, 1'b0);
    start_pulse();
    wait_done(3'd3);

    // 5: CMD8 never answered -> timeout after 100 cycles.
    push(6'd0, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd8, 2'b10, 32'h1AA, 0, 40'd0);
    push_done(3'd6, 1'b0, 1'b0);
    exp_tmo = 1;
    start_pulse();
    wait_done(3'd6);
    chk("timeout_reset_seen", 64'(exp_tmo), 64'd0);

    // 6: byte port stalls during dummy bytes; reset while waiting on ACMD41.
    push(6'd0, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd8, 2'b10, 32'h1AA, 1, 40'h01_000001AA);
    push(6'd55, 2'b00, 32'd0, 1, 40'h01_00000000);
    push(6'd41, 2'b00, 32'h40000000, 0, 40'd0);
    seen_acmd41 = 0;
    start_pulse();
    repeat (3) @(posedge clk);
    #1 i_ll_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_ll_busy = 1'b0;
    begin
      bit got = 0;
      for (int k = 0; k < 1000; k++) begin
        @(posedge clk);
        if (seen_acmd41) begin got = 1; break; end
      end
      chk("acmd41_reached", 64'(got), 64'd1);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("after_reset");
    chk("no_done_after_reset", 64'(exp_done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
